// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Owns the architectural PC, drives the PC mux selects, runs the
//            imem req/ack fetch handshake and hands one buffered instruction
//            at a time to decode. Redirects from execute flush wrong-path
//            fetches.
// Options  : PC_ALIGN_CHECK_EN - force pc[1:0] to zero on load and pulse
//            misalign for a misaligned redirect.
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_next,
  output logic [31:0] pc_plus_4,
  output logic [31:0] pc_target,
  output logic        PCSel,
  input  logic        br_valid,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        if_ready,
  output logic        misalign
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [31:0] redir_pc;
  logic        redir_pending;
  // One-cycle gap in REQ after a redirected ack, so the new address is
  // presented on a fresh request rather than mid-request.
  logic        bubble;
  logic        bubble_nxt;
  logic        redir;
  logic        pc_load;
  logic        buf_load;
  logic        buf_clear;
  logic [31:0] pc_load_val;

  assign redir     = br_valid & br_taken;
  assign PCSel     = ~rst & (redir | redir_pending);
  // A live redirect takes priority over one held from an earlier cycle.
  assign pc_target = redir ? br_target : redir_pc;
  assign pc_plus_4 = (rst ? RESET_PC : pc) + 32'd4;
  assign imem_addr = pc;

`ifdef PC_ALIGN_CHECK_EN
  logic mis_nxt;
  assign pc_load_val = {pc_next[31:2], 2'b00};
  assign mis_nxt     = pc_load & PCSel & (pc_target[1:0] != 2'b00);

  // Misalign flag: registered so it lines up with the pc update.
  always_ff @(posedge clk) begin
    if (rst) misalign <= 1'b0;
    else     misalign <= mis_nxt;
  end
`else
  assign pc_load_val = pc_next;
  assign misalign    = 1'b0;
`endif

  // Next-state and handshake decode.
  always_comb begin
    state_nxt  = state;
    imem_req   = 1'b0;
    pc_load    = 1'b0;
    buf_load   = 1'b0;
    buf_clear  = 1'b0;
    bubble_nxt = 1'b0;
    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        imem_req = ~bubble;
        if (!bubble && imem_ack) begin
          pc_load = 1'b1;
          if (PCSel) begin
            bubble_nxt = 1'b1;      // wrong-path data is dropped
          end else begin
            buf_load  = 1'b1;
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (PCSel) begin
          buf_clear = 1'b1;         // flush beats a consume
          pc_load   = 1'b1;
          state_nxt = REQ;
        end else if (if_ready) begin
          buf_clear = 1'b1;
          state_nxt = REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register and request gap flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      bubble <= 1'b0;
    end else begin
      state  <= state_nxt;
      bubble <= bubble_nxt;
    end
  end

  // Program counter and deferred redirect capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc            <= RESET_PC;
      redir_pending <= 1'b0;
      redir_pc      <= 32'h0;
    end else if (pc_load) begin
      pc            <= pc_load_val;
      redir_pending <= 1'b0;
    end else if (redir) begin
      redir_pending <= 1'b1;
      redir_pc      <= br_target;
    end
  end

  // Decode-side instruction buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_valid <= 1'b0;
      if_pc    <= 32'h0;
      if_instr <= 32'h0;
    end else if (buf_load) begin
      if_valid <= 1'b1;
      if_pc    <= pc;
      if_instr <= imem_rdata;
    end else if (buf_clear) begin
      if_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
# pc_sequencer

Owns the architectural program counter and sequences instruction fetch. It drives the PC mux select inputs: sequential address, redirect target and select. It takes the muxed next PC back and registers it. It runs a request/acknowledge fetch handshake with instruction memory and delivers one buffered instruction at a time to decode. Branch/jump redirects from execute can arrive in any cycle; they flush wrong-path fetches.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- pc_next  in  32  muxed next PC returned from the PC mux
- pc_plus_4  out  32  current PC + 4 (combinational)
- pc_target  out  32  redirect target to PC mux (combinational)
- PCSel  out  1  0: select pc_plus_4, 1: select pc_target (combinational)
- br_valid  in  1  execute reports a resolved control-flow instruction this cycle
- br_taken  in  1  qualified by br_valid; redirect required
- br_target  in  32  redirect address, qualified by br_valid & br_taken
- imem_req  out  1  fetch request; held high until imem_ack
- imem_addr  out  32  fetch address, stable while imem_req high
- imem_ack  in  1  memory returns imem_rdata this cycle; only valid while imem_req high
- imem_rdata  in  32  fetched instruction word
- if_valid  out  1  if_instr/if_pc hold a valid instruction
- if_pc  out  32  address of if_instr
- if_instr  out  32  buffered instruction
- if_ready  in  1  decode consumes the buffer this cycle when if_valid high
- misalign  out  1  one-cycle pulse, misaligned redirect (see Configuration)

## Operation
- Registers: pc, state, redir_pending, redir_pc, output buffer (if_valid, if_pc, if_instr).
- Arithmetic:
  - pc_plus_4 = pc + 32'd4, mod 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000.
  - imem_addr = pc.
- Redirect event: redir = br_valid & br_taken.
- Mux drive:
  - PCSel = redir | redir_pending.
  - pc_target = redir ? br_target : redir_pc. A live redirect wins over a pending one.
- redir in any state with no pc update that cycle: redir_pending <= 1, redir_pc <= br_target. Any pc update clears redir_pending.
- States:
  - IDLE: imem_req = 0. Next state REQ.
  - REQ: imem_req = 1.
    - On imem_ack with PCSel = 1: discard imem_rdata, pc <= pc_next, stay REQ. imem_req drops for one cycle before the new address.
    - On imem_ack with PCSel = 0: if_valid <= 1, if_pc <= pc, if_instr <= imem_rdata, pc <= pc_next (= pc + 4), go to HOLD.
  - HOLD: imem_req = 0, if_valid = 1.
    - redir or redir_pending: if_valid <= 0 (flush), pc <= pc_next, go to REQ.
    - Otherwise, if_ready: if_valid <= 0, go to REQ.
- Decode never sees a wrong-path instruction after a redirect has been signalled.

## Timing
- Reset values: pc = RESET_PC, state = IDLE, imem_req = 0, if_valid = 0, if_pc = 0, if_instr = 0, redir_pending = 0, misalign = 0.
  - While rst is high: pc_plus_4 = RESET_PC + 4 and PCSel = 0.
- Reset mid-handshake: the outstanding request is abandoned. The memory must drop any ack that arrives after reset; the block ignores imem_ack outside REQ.
- First imem_req is asserted 2 cycles after rst deasserts (IDLE, then REQ).
- Zero-wait memory (ack in the first REQ cycle): if_valid rises on the next edge. Peak throughput is 1 instruction per 2 cycles.
- Simultaneous redir and imem_ack in REQ: the ack data is dropped and pc takes br_target on the same edge.
- Simultaneous redir and if_ready in HOLD: the flush wins, and pc <= br_target.
- A redirect arriving while the fetch is outstanding is held pending and applied at ack.

## Configuration
- PC_ALIGN_CHECK_EN defined:
  - When a redirect is applied to pc with pc_target[1:0] != 2'b00, misalign pulses high for exactly one cycle (registered, aligned with the pc update).
  - The PC mux still receives pc_target unmodified; pc loads pc_next with bits [1:0] forced to 0.
- PC_ALIGN_CHECK_EN undefined:
  - misalign is tied to 0.
  - pc loads pc_next verbatim; no alignment check.

## Test plan
- Reset, RESET_PC = 32'h0000_1000, memory acks in the same cycle, if_ready = 1 → imem_addr sequence 0x1000, 0x1004, 0x1008; if_valid pulses every 2nd cycle with matching if_pc.
- Memory with 3-cycle ack latency, br_valid & br_taken with br_target = 0x2000 on latency cycle 1 → ack data discarded, if_valid stays 0, next imem_addr = 0x2000.
- HOLD with if_ready = 0 for 5 cycles → if_valid, if_pc and if_instr stable; imem_req = 0 throughout.
- HOLD with if_ready = 1 and redirect to 0x3000 in the same cycle → if_valid = 0 next cycle, no consume recorded, next fetch at 0x3000.
- pc = 32'hFFFF_FFFC, fetch completes → pc_plus_4 = 0, next imem_addr = 32'h0000_0000.
- PC_ALIGN_CHECK_EN defined, redirect to 0x2002 → misalign high for exactly 1 cycle, next imem_addr = 0x2000. Macro undefined → misalign = 0 and next imem_addr = 0x2002.
